// File: rtl/rr_onehot_arbiter.sv
// -----------------------------------------------------------------------------
// rr_onehot_arbiter
//
// Round-robin arbiter for N requesters with a registered one-hot grant.
// The owner keeps the grant until it asserts done or drops its request.
// Priority then rotates to the requester just past the released owner. The
// same cycle re-arbitrates, so back-to-back grants have no idle bubble.
//
// Optional build macro: ARB_TIMEOUT_EN
//   When defined, an 8-bit hold counter forces a release once a single grant
//   has been held for MAX_HOLD cycles. timeout pulses for that one cycle.
//   When undefined, timeout is constant 0 and a grant is held indefinitely.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   req[N]       request vector, bit i = requester i
//   done         current owner finished (sampled only while grant_valid=1)
//   grant[N]     registered one-hot grant, or all zero
//   grant_valid  high when grant is non-zero
//   grant_idx    binary index of the granted bit, 0 when idle
//   timeout      one-cycle pulse on a forced release
// -----------------------------------------------------------------------------
module rr_onehot_arbiter #(
    parameter int N        = 8,
    parameter int IDX_W    = $clog2(N),
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic             done,
    output logic [N-1:0]     grant,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    output logic             timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state, state_n;
    logic [N-1:0]       grant_n;
    logic [IDX_W-1:0]   idx_n;
    logic [IDX_W-1:0]   ptr, ptr_n;
    logic [IDX_W-1:0]   scan_base;
    logic               pick_hit;
    logic [IDX_W-1:0]   pick_idx;
    logic               load;
    logic               release_now;
    logic               tmo;

    // Index one past i, wrapping N-1 -> 0 (N need not be a power of two).
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        if (int'(i) == N - 1)
            return '0;
        else
            return i + IDX_W'(1);
    endfunction

    // First set bit of r scanning base, base+1, ..., wrapping. Walking the
    // offsets from farthest to nearest lets the nearest hit overwrite the
    // rest without an early loop exit. Result is {hit, index}.
    function automatic logic [IDX_W:0] pick(input logic [N-1:0] r,
                                            input logic [IDX_W-1:0] base);
        logic [IDX_W:0] res;
        int             j;
        res = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(base) + k;
            if (j >= N)
                j = j - N;
            if (r[IDX_W'(j)])
                res = {1'b1, IDX_W'(j)};
        end
        return res;
    endfunction

    // While busy, a release re-arbitrates from one past the owner; this also
    // puts the owner's own request last in line. While idle, scan from ptr.
    assign scan_base            = (state == BUSY) ? next_idx(grant_idx) : ptr;
    assign {pick_hit, pick_idx} = pick(req, scan_base);

    // done and request withdrawal in the same cycle are one release.
    assign release_now = done | ~req[grant_idx] | tmo;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_cnt;

    assign tmo     = (state == BUSY) && (hold_cnt == 8'(MAX_HOLD - 1));
    assign timeout = tmo;

    // Hold counter: restarts with every newly loaded grant.
    always_ff @(posedge clk) begin
        if (reset)
            hold_cnt <= '0;
        else if (load)
            hold_cnt <= '0;
        else if (state == BUSY)
            hold_cnt <= hold_cnt + 8'd1;
    end
`else
    logic unused_cfg;

    assign tmo        = 1'b0;
    assign timeout    = 1'b0;
    assign unused_cfg = ^{1'b0, 32'(MAX_HOLD)};
`endif

    always_comb begin
        state_n = state;
        grant_n = grant;
        idx_n   = grant_idx;
        ptr_n   = ptr;
        load    = 1'b0;

        case (state)
            IDLE: begin
                if (pick_hit)
                    load = 1'b1;
            end
            BUSY: begin
                if (release_now) begin
                    ptr_n = scan_base;
                    if (pick_hit) begin
                        load = 1'b1;
                    end else begin
                        grant_n = '0;
                        idx_n   = '0;
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
                idx_n   = '0;
            end
        endcase

        if (load) begin
            grant_n = N'(1) << pick_idx;
            idx_n   = pick_idx;
            state_n = BUSY;
        end
    end

    // Grant register: the only source of grant, no req-to-grant comb path.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= '0;
            grant_idx <= '0;
            ptr       <= '0;
        end else begin
            state     <= state_n;
            grant     <= grant_n;
            grant_idx <= idx_n;
            ptr       <= ptr_n;
        end
    end

    assign grant_valid = (state == BUSY);

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_onehot_arbiter
//
// Bench for rr_onehot_arbiter (N=8, MAX_HOLD=4). A vector table covers reset,
// rotation, wrap, release-to-idle, reset mid-grant and combined done/withdraw.
// Hand-written sequences cover the long-hold / forced-release behaviour.
// Expected outputs are queued as each stimulus is clocked in and compared on
// the following falling edge; a monitor checks grant is zero/one-hot each
// cycle and consistent with grant_valid and grant_idx.
// -----------------------------------------------------------------------------
module tb_rr_onehot_arbiter;

    localparam int N  = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req;
    logic          done;
    logic [N-1:0]  grant;
    logic          grant_valid;
    logic [IW-1:0] grant_idx;
    logic          timeout;

    always #5 clk = ~clk;

    rr_onehot_arbiter #(
        .N        (N),
        .MAX_HOLD (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .timeout     (timeout)
    );

    typedef struct {
        logic          rst;
        logic [N-1:0]  req;
        logic          done;
        logic [N-1:0]  eg;
        logic [IW-1:0] ei;
    } vec_t;

    typedef struct {
        logic [N-1:0]  g;
        logic [IW-1:0] i;
        logic          t;
        int            id;
    } exp_t;

    exp_t sb[$];
    int   n_chk   = 0;
    int   n_fail  = 0;
    int   step_no = 0;
    logic mon_en  = 1'b0;

    vec_t tbl[33];

    task automatic step(input logic r, input logic [N-1:0] rq, input logic d,
                        input logic [N-1:0] eg, input logic [IW-1:0] ei,
                        input logic et);
        exp_t e;
        reset = r;
        req   = rq;
        done  = d;
        @(posedge clk);
        e.g  = eg;
        e.i  = ei;
        e.t  = et;
        e.id = step_no;
        step_no++;
        sb.push_back(e);
        mon_en = 1'b1;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            n_chk++;
            if (!$onehot0(grant) || (grant_valid !== (grant != '0))) begin
                n_fail++;
                $display("FAIL onehot_mon t=%0t grant=%h valid=%b, need zero/one-hot and valid==|grant",
                         $time, grant, grant_valid);
            end
            n_chk++;
            if (grant_valid && (grant !== (N'(1) << grant_idx))) begin
                n_fail++;
                $display("FAIL idx_mon t=%0t grant=%h idx=%0d, need grant==1<<idx",
                         $time, grant, grant_idx);
            end
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_chk++;
            if (grant !== e.g || grant_idx !== e.i ||
                grant_valid !== (e.g != '0) || timeout !== e.t) begin
                n_fail++;
                $display("FAIL step%0d got grant=%h idx=%0d valid=%b timeout=%b, expected grant=%h idx=%0d valid=%b timeout=%b",
                         e.id, grant, grant_idx, grant_valid, timeout,
                         e.g, e.i, (e.g != '0), e.t);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //           rst   req    done  grant  idx
        tbl[0]  = '{1'b1, 8'hFF, 1'b0, 8'h00, 3'd0};
        tbl[1]  = '{1'b1, 8'hFF, 1'b0, 8'h00, 3'd0};
        tbl[2]  = '{1'b0, 8'hFF, 1'b0, 8'h01, 3'd0};
        tbl[3]  = '{1'b0, 8'hFF, 1'b1, 8'h02, 3'd1};
        tbl[4]  = '{1'b0, 8'hFF, 1'b1, 8'h04, 3'd2};
        tbl[5]  = '{1'b0, 8'hFF, 1'b1, 8'h08, 3'd3};
        tbl[6]  = '{1'b0, 8'hFF, 1'b1, 8'h10, 3'd4};
        tbl[7]  = '{1'b0, 8'hFF, 1'b1, 8'h20, 3'd5};
        tbl[8]  = '{1'b0, 8'hFF, 1'b1, 8'h40, 3'd6};
        tbl[9]  = '{1'b0, 8'hFF, 1'b1, 8'h80, 3'd7};
        tbl[10] = '{1'b0, 8'hFF, 1'b1, 8'h01, 3'd0};
        tbl[11] = '{1'b0, 8'h04, 1'b1, 8'h04, 3'd2};
        tbl[12] = '{1'b0, 8'h03, 1'b0, 8'h01, 3'd0};
        tbl[13] = '{1'b0, 8'h00, 1'b0, 8'h00, 3'd0};
        tbl[14] = '{1'b0, 8'h00, 1'b0, 8'h00, 3'd0};
        tbl[15] = '{1'b0, 8'h08, 1'b0, 8'h08, 3'd3};
        tbl[16] = '{1'b0, 8'h28, 1'b0, 8'h08, 3'd3};
        tbl[17] = '{1'b0, 8'h20, 1'b0, 8'h20, 3'd5};
        tbl[18] = '{1'b0, 8'h20, 1'b1, 8'h20, 3'd5};
        tbl[19] = '{1'b0, 8'h00, 1'b0, 8'h00, 3'd0};
        tbl[20] = '{1'b0, 8'h40, 1'b0, 8'h40, 3'd6};
        tbl[21] = '{1'b0, 8'h40, 1'b1, 8'h40, 3'd6};
        tbl[22] = '{1'b1, 8'h40, 1'b0, 8'h00, 3'd0};
        tbl[23] = '{1'b0, 8'hC0, 1'b0, 8'h40, 3'd6};
        tbl[24] = '{1'b0, 8'hC0, 1'b0, 8'h40, 3'd6};
        tbl[25] = '{1'b0, 8'h00, 1'b0, 8'h00, 3'd0};
        tbl[26] = '{1'b0, 8'h00, 1'b1, 8'h00, 3'd0};
        tbl[27] = '{1'b0, 8'h02, 1'b1, 8'h02, 3'd1};
        tbl[28] = '{1'b0, 8'h02, 1'b0, 8'h02, 3'd1};
        tbl[29] = '{1'b0, 8'h00, 1'b0, 8'h00, 3'd0};
        tbl[30] = '{1'b0, 8'h0C, 1'b0, 8'h04, 3'd2};
        tbl[31] = '{1'b0, 8'h0A, 1'b1, 8'h08, 3'd3};
        tbl[32] = '{1'b0, 8'h00, 1'b0, 8'h00, 3'd0};

        reset = 1'b1;
        req   = '0;
        done  = 1'b0;

        for (int k = 0; k < 33; k++)
            step(tbl[k].rst, tbl[k].req, tbl[k].done, tbl[k].eg, tbl[k].ei, 1'b0);

        // Idle here with the priority pointer at 4.
`ifdef ARB_TIMEOUT_EN
        for (int k = 0; k < 3; k++)
            step(1'b0, 8'h03, 1'b0, 8'h01, 3'd0, 1'b0);
        step(1'b0, 8'h03, 1'b0, 8'h01, 3'd0, 1'b1);
        step(1'b0, 8'h03, 1'b0, 8'h02, 3'd1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0);
`else
        for (int k = 0; k < 20; k++)
            step(1'b0, 8'h03, 1'b0, 8'h01, 3'd0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0);
        step(1'b0, 8'h08, 1'b0, 8'h08, 3'd3, 1'b0);
        for (int k = 0; k < 10; k++)
            step(1'b0, 8'h28, 1'b0, 8'h08, 3'd3, 1'b0);
        step(1'b0, 8'h20, 1'b0, 8'h20, 3'd5, 1'b0);
        step(1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0);
`endif

        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
